// File: rtl/ht_table_init_engine.sv
`default_nettype none
// ============================================================================
//  Module   : ht_table_init_engine
//  Purpose  : Hash-table RAM init engine. For each accepted task it writes a
//             fill word over the address range [start, end] on up to NUM_CH
//             RAM write channels in lockstep. It can also clear and refill the
//             empty-pointer storage with the same addresses. One result word is
//             reported per task.
//  Options  : HT_INIT_CYCLE_STAT_EN - when defined, adds a saturating cycle
//             statistic (res_cycles_o) and its clear input (stat_clr_i).
//  Ports    : clk_i/rst_i     clock, asynchronous active-high reset
//             task_*          task request (valid/ready handshake)
//             busy_o          a task is in progress
//             wr_*            shared RAM write port, per-channel enables
//             fl_*            empty-pointer storage reset and add strobes
//             res_*           result word (valid/ready handshake)
//  Revision : 1.0 - initial release
// ============================================================================
module ht_table_init_engine #(
    parameter int NUM_CH   = 2,
    parameter int A_WIDTH  = 10,
    parameter int D_WIDTH  = 64,
    parameter int RC_WIDTH = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [A_WIDTH-1:0]  task_start_i,
    input  logic [A_WIDTH-1:0]  task_end_i,
    input  logic [D_WIDTH-1:0]  task_fill_i,
    input  logic [NUM_CH-1:0]   task_ch_mask_i,
    input  logic                task_fl_en_i,
    input  logic                task_valid_i,
    output logic                task_ready_o,
    output logic                busy_o,
    input  logic                wr_stall_i,
    output logic [A_WIDTH-1:0]  wr_addr_o,
    output logic [D_WIDTH-1:0]  wr_data_o,
    output logic [NUM_CH-1:0]   wr_en_o,
    output logic                fl_srst_o,
    output logic [A_WIDTH-1:0]  fl_add_ptr_o,
    output logic                fl_add_en_o,
    output logic [RC_WIDTH-1:0] res_rescode_o,
    output logic [A_WIDTH:0]    res_count_o,
    output logic                res_valid_o,
`ifdef HT_INIT_CYCLE_STAT_EN
    input  logic                stat_clr_i,
    output logic [31:0]         res_cycles_o,
`endif
    input  logic                res_ready_i
);

    localparam logic [RC_WIDTH-1:0] C_RC_OK        = RC_WIDTH'(0);
    localparam logic [RC_WIDTH-1:0] C_RC_ERR_RANGE = RC_WIDTH'(1);
    localparam logic [RC_WIDTH-1:0] C_RC_ERR_MASK  = RC_WIDTH'(2);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FL_SRST = 2'd1,
        S_INIT    = 2'd2,
        S_REPORT  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [A_WIDTH-1:0]  r_cnt;
    logic [A_WIDTH-1:0]  r_end;
    logic [D_WIDTH-1:0]  r_fill;
    logic [NUM_CH-1:0]   r_mask;
    logic                r_fl_en;
    logic [RC_WIDTH-1:0] r_rescode;
    logic [A_WIDTH:0]    r_count;

    logic w_accept;
    logic w_wr_fire;
    logic w_last;
    logic w_range_err;
    logic w_mask_err;

    assign w_range_err = (task_start_i > task_end_i);
    assign w_mask_err  = (task_ch_mask_i == '0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_wr_fire   = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (task_valid_i) begin
                    w_accept = 1'b1;
                    if (w_range_err || w_mask_err) begin
                        w_state_nxt = S_REPORT;
                    end else if (task_fl_en_i) begin
                        w_state_nxt = S_FL_SRST;
                    end else begin
                        w_state_nxt = S_INIT;
                    end
                end
            end
            S_FL_SRST: begin
                w_state_nxt = S_INIT;
            end
            S_INIT: begin
                if (!wr_stall_i) begin
                    w_wr_fire = 1'b1;
                    // Compare before incrementing so a range ending at the
                    // top address finishes without wrapping back to 0.
                    if (r_cnt == r_end) begin
                        w_last      = 1'b1;
                        w_state_nxt = S_REPORT;
                    end
                end
            end
            S_REPORT: begin
                if (res_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Task latch, address counter and result word
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt     <= '0;
            r_end     <= '0;
            r_fill    <= '0;
            r_mask    <= '0;
            r_fl_en   <= 1'b0;
            r_rescode <= '0;
            r_count   <= '0;
        end else if (w_accept) begin
            r_cnt   <= task_start_i;
            r_end   <= task_end_i;
            r_fill  <= task_fill_i;
            r_mask  <= task_ch_mask_i;
            r_fl_en <= task_fl_en_i;
            if (w_range_err) begin
                r_rescode <= C_RC_ERR_RANGE;
                r_count   <= '0;
            end else if (w_mask_err) begin
                r_rescode <= C_RC_ERR_MASK;
                r_count   <= '0;
            end else begin
                r_rescode <= C_RC_OK;
                // One bit wider than the address so a full-range task
                // reports 2^A_WIDTH.
                r_count   <= {1'b0, task_end_i} - {1'b0, task_start_i}
                             + {{A_WIDTH{1'b0}}, 1'b1};
            end
        end else if (w_wr_fire && !w_last) begin
            r_cnt <= r_cnt + {{(A_WIDTH-1){1'b0}}, 1'b1};
        end
    end

`ifdef HT_INIT_CYCLE_STAT_EN
    // ------------------------------------------------------------------
    // Cycle statistic: the accept cycle counts as 1, then every cycle in
    // FL_SRST/INIT (stalled or not) adds one until REPORT is reached.
    // ------------------------------------------------------------------
    logic [31:0] r_cycles;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cycles <= '0;
        end else if (stat_clr_i) begin
            r_cycles <= '0;
        end else if (w_accept) begin
            r_cycles <= 32'd1;
        end else if (((r_state == S_FL_SRST) || (r_state == S_INIT))
                     && (r_cycles != 32'hFFFF_FFFF)) begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    assign res_cycles_o = r_cycles;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Ready is forced low while reset is held even though the state is IDLE.
    assign task_ready_o  = (r_state == S_IDLE) && !rst_i;
    assign busy_o        = (r_state != S_IDLE);
    assign wr_addr_o     = r_cnt;
    assign wr_data_o     = r_fill;
    assign wr_en_o       = w_wr_fire ? r_mask : '0;
    assign fl_srst_o     = (r_state == S_FL_SRST);
    assign fl_add_ptr_o  = r_cnt;
    assign fl_add_en_o   = w_wr_fire && r_fl_en;
    assign res_valid_o   = (r_state == S_REPORT);
    assign res_rescode_o = r_rescode;
    assign res_count_o   = r_count;

endmodule
`default_nettype wire
